// File: rtl/key_event_decoder.sv
// Key gesture decoder: turns a debounced key level into CLICK / DCLICK / LONG (/ REPEAT) events.
// Optional build macro KEY_AUTO_REPEAT_EN adds periodic REPEAT events while a long press is held.
module key_event_decoder #(
   parameter int LONG_CYC   = 100,
   parameter int DCLK_CYC   = 40,
   parameter int REPEAT_CYC = 20,
   parameter int CNT_W      = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_n,
   input  logic       event_ready,
   input  logic       ovr_clr,
   output logic       event_valid,
   output logic [1:0] event_code,
   output logic       overrun
);

   typedef enum logic [2:0] {
      IDLE,
      PRESS1,
      WAIT2,
      PRESS2,
      HOLD
   } state_t;

   localparam logic [1:0] EV_CLICK  = 2'd0;
   localparam logic [1:0] EV_DCLICK = 2'd1;
   localparam logic [1:0] EV_LONG   = 2'd2;

   localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] DCLK_TERM = CNT_W'(DCLK_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

`ifdef KEY_AUTO_REPEAT_EN
   localparam logic [1:0]       EV_REPEAT   = 2'd3;
   localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYC - 1);
`else
   logic unused_repeat_cyc;
   assign unused_repeat_cyc = |REPEAT_CYC;
`endif

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] cnt;
   logic             key_q;
   logic             issue;
   logic [1:0]       issue_code;
   logic             cnt_restart;
   logic             load;
   logic             drop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q <= 1'b1;
         state <= IDLE;
      end else begin
         key_q <= key_n;
         state <= next_state;
      end
   end

   // Release beats the long-press terminal count; a second press beats the click timeout.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (!key_q) next_state = PRESS1;
         PRESS1: begin
            if (key_q)                  next_state = WAIT2;
            else if (cnt == LONG_TERM)  next_state = HOLD;
         end
         WAIT2: begin
            if (!key_q)                 next_state = PRESS2;
            else if (cnt == DCLK_TERM)  next_state = IDLE;
         end
         PRESS2:  if (key_q) next_state = IDLE;
         HOLD:    if (key_q) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      issue       = 1'b0;
      issue_code  = EV_CLICK;
      cnt_restart = 1'b0;
      case (state)
         PRESS1: begin
            if (!key_q && cnt == LONG_TERM) begin
               issue      = 1'b1;
               issue_code = EV_LONG;
            end
         end
         WAIT2: begin
            if (key_q && cnt == DCLK_TERM) begin
               issue      = 1'b1;
               issue_code = EV_CLICK;
            end
         end
         PRESS2: begin
            if (key_q) begin
               issue      = 1'b1;
               issue_code = EV_DCLICK;
            end
         end
`ifdef KEY_AUTO_REPEAT_EN
         HOLD: begin
            if (!key_q && cnt == REPEAT_TERM) begin
               issue       = 1'b1;
               issue_code  = EV_REPEAT;
               cnt_restart = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (next_state != state || cnt_restart) begin
         cnt <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + 1'b1;
      end
   end

   // The FSM never waits for the consumer: an event that finds the slot occupied is dropped.
   assign load = issue && (!event_valid || event_ready);
   assign drop = issue && event_valid && !event_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         event_valid <= 1'b0;
         event_code  <= EV_CLICK;
         overrun     <= 1'b0;
      end else begin
         if (load) begin
            event_valid <= 1'b1;
            event_code  <= issue_code;
         end else if (event_valid && event_ready) begin
            event_valid <= 1'b0;
         end
         if (drop) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: directed gesture scenarios plus randomized key traffic,
// compared cycle by cycle against a timestamp-based gesture model.
module tb_key_event_decoder;

   localparam int LONG_CYC   = 100;
   localparam int DCLK_CYC   = 40;
   localparam int REPEAT_CYC = 20;
   localparam int CNT_W      = 24;
`ifdef KEY_AUTO_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   localparam int QUIET       = 0;
   localparam int FIRST_DOWN  = 1;
   localparam int GAP         = 2;
   localparam int SECOND_DOWN = 3;
   localparam int LONG_HOLD   = 4;

   logic       clk;
   logic       rst_n;
   logic       key_n;
   logic       event_ready;
   logic       ovr_clr;
   logic       event_valid;
   logic [1:0] event_code;
   logic       overrun;

   int errors;
   int checks;
   int ev_seen [4];
   int valid_cycles;

   int m_phase;
   int m_since;
   int m_now;
   bit m_keyq;
   bit m_valid;
   int m_code;
   bit m_ovr;

   key_event_decoder #(
      .LONG_CYC  (LONG_CYC),
      .DCLK_CYC  (DCLK_CYC),
      .REPEAT_CYC(REPEAT_CYC),
      .CNT_W     (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_n      (key_n),
      .event_ready(event_ready),
      .ovr_clr    (ovr_clr),
      .event_valid(event_valid),
      .event_code (event_code),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      m_phase = QUIET;
      m_since = 0;
      m_now   = 0;
      m_keyq  = 1'b1;
      m_valid = 1'b0;
      m_code  = 0;
      m_ovr   = 1'b0;
   endtask

   // Gesture rules in terms of how long the current phase has lasted (now - since).
   task automatic modelStep(input bit k, input bit rdy, input bit clr);
      int  elapsed;
      int  nph;
      int  ev;
      bit  dropped;
      elapsed = m_now - m_since;
      nph     = m_phase;
      ev      = -1;
      case (m_phase)
         QUIET:       if (!m_keyq) nph = FIRST_DOWN;
         FIRST_DOWN: begin
            if (m_keyq) nph = GAP;
            else if (elapsed == LONG_CYC - 1) begin nph = LONG_HOLD; ev = 2; end
         end
         GAP: begin
            if (!m_keyq) nph = SECOND_DOWN;
            else if (elapsed == DCLK_CYC - 1) begin nph = QUIET; ev = 0; end
         end
         SECOND_DOWN: if (m_keyq) begin nph = QUIET; ev = 1; end
         default: begin
            if (m_keyq) nph = QUIET;
            else if (REP_EN && elapsed == REPEAT_CYC - 1) begin ev = 3; m_since = m_now + 1; end
         end
      endcase
      if (nph != m_phase) m_since = m_now + 1;
      m_phase = nph;
      dropped = 1'b0;
      if (ev >= 0) begin
         if (!m_valid || rdy) begin
            m_valid = 1'b1;
            m_code  = ev;
         end else begin
            dropped = 1'b1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      if (dropped) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      m_keyq = k;
      m_now++;
   endtask

   // One clock: drive inputs, advance the model at the edge, compare just after it.
   task automatic applyStimulus(input bit k, input bit rdy, input bit clr);
      key_n       = k;
      event_ready = rdy;
      ovr_clr     = clr;
      @(posedge clk);
      modelStep(k, rdy, clr);
      #1;
      checkOutput("event_valid", int'(event_valid), int'(m_valid));
      checkOutput("event_code", int'(event_code), m_code);
      checkOutput("overrun", int'(overrun), int'(m_ovr));
      if (event_valid) begin
         valid_cycles++;
         ev_seen[event_code]++;
      end
   endtask

   task automatic runLevel(input bit k, input int n, input bit rdy);
      for (int i = 0; i < n; i++) applyStimulus(k, rdy, 1'b0);
   endtask

   task automatic clearTally();
      for (int i = 0; i < 4; i++) ev_seen[i] = 0;
      valid_cycles = 0;
   endtask

   // Reset is asserted between edges so its asynchronous effect is visible immediately.
   task automatic doReset(input bit k_during);
      #2;
      rst_n       = 1'b0;
      key_n       = k_during;
      event_ready = 1'b0;
      ovr_clr     = 1'b0;
      modelReset();
      #1;
      checkOutput("rst_event_valid", int'(event_valid), 0);
      checkOutput("rst_event_code", int'(event_code), 0);
      checkOutput("rst_overrun", int'(overrun), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int long_at;
      int level;
      int dur;
      errors      = 0;
      checks      = 0;
      rst_n       = 1'b1;
      key_n       = 1'b1;
      event_ready = 1'b0;
      ovr_clr     = 1'b0;
      clearTally();
      modelReset();

      doReset(1'b1);
      runLevel(1'b1, 5, 1'b1);

      $display("[TB] single click");
      clearTally();
      runLevel(1'b0, 10, 1'b1);
      runLevel(1'b1, 60, 1'b1);
      checkOutput("click_count", ev_seen[0], 1);
      checkOutput("click_valid_cycles", valid_cycles, 1);

      $display("[TB] double click");
      clearTally();
      runLevel(1'b0, 10, 1'b1);
      runLevel(1'b1, 15, 1'b1);
      runLevel(1'b0, 10, 1'b1);
      runLevel(1'b1, 60, 1'b1);
      checkOutput("dclick_count", ev_seen[1], 1);
      checkOutput("dclick_no_click", ev_seen[0], 0);
      checkOutput("dclick_valid_cycles", valid_cycles, 1);

      $display("[TB] long hold");
      clearTally();
      long_at = -1;
      for (int i = 0; i < 200; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         if (event_valid && event_code == 2'd2 && long_at < 0) long_at = i;
      end
      runLevel(1'b1, 60, 1'b1);
      checkOutput("long_latency", long_at, LONG_CYC + 1);
      checkOutput("long_count", ev_seen[2], 1);
`ifdef KEY_AUTO_REPEAT_EN
      checkOutput("repeat_count", ev_seen[3], 4);
      checkOutput("long_valid_cycles", valid_cycles, 5);
`else
      checkOutput("repeat_count", ev_seen[3], 0);
      checkOutput("long_valid_cycles", valid_cycles, 1);
`endif

      $display("[TB] overrun with stalled consumer");
`ifdef KEY_AUTO_REPEAT_EN
      runLevel(1'b0, 130, 1'b0);
      runLevel(1'b1, 5, 1'b0);
`else
      runLevel(1'b0, 110, 1'b0);
      runLevel(1'b1, 5, 1'b0);
      runLevel(1'b0, 5, 1'b0);
      runLevel(1'b1, 50, 1'b0);
`endif
      checkOutput("ovr_valid_held", int'(event_valid), 1);
      checkOutput("ovr_code_held", int'(event_code), 2);
      checkOutput("ovr_set", int'(overrun), 1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("ovr_cleared", int'(overrun), 0);
      checkOutput("ovr_code_after_clr", int'(event_code), 2);

      $display("[TB] reset during click gap");
      runLevel(1'b0, 10, 1'b0);
      runLevel(1'b1, 10, 1'b0);
      doReset(1'b1);
      clearTally();
      runLevel(1'b1, 60, 1'b1);
      checkOutput("no_click_after_reset", valid_cycles, 0);

      $display("[TB] key held through reset");
      runLevel(1'b0, 20, 1'b1);
      doReset(1'b0);
      clearTally();
      runLevel(1'b0, 120, 1'b1);
      checkOutput("long_after_reset", ev_seen[2], 1);
      runLevel(1'b1, 60, 1'b1);

      $display("[TB] terminal-count boundaries");
      for (int g = DCLK_CYC - 3; g <= DCLK_CYC + 2; g++) begin
         runLevel(1'b0, 5, 1'b1);
         runLevel(1'b1, g, 1'b1);
         runLevel(1'b0, 5, 1'b1);
         runLevel(1'b1, DCLK_CYC + 10, 1'b1);
      end
      for (int p = LONG_CYC - 1; p <= LONG_CYC + 2; p++) begin
         runLevel(1'b0, p, 1'b1);
         runLevel(1'b1, DCLK_CYC + 10, 1'b1);
      end

      $display("[TB] randomized traffic");
      level = 1;
      for (int seg = 0; seg < 250; seg++) begin
         if (seg % 80 == 79) doReset(1'($urandom_range(0, 1)));
         level = 1 - level;
         if ($urandom_range(0, 3) == 0) dur = $urandom_range(LONG_CYC - 5, LONG_CYC + 70);
         else dur = $urandom_range(1, DCLK_CYC + 8);
         for (int i = 0; i < dur; i++)
            applyStimulus(1'(level), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      end
      runLevel(1'b1, DCLK_CYC + 10, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter LONG_CYC, default 100: held cycles in PRESS1 before LONG is issued.
REQ-002 Parameter DCLK_CYC, default 40: released-gap cycles in WAIT2 before a lone press resolves to CLICK.
REQ-003 Parameter REPEAT_CYC, default 20: REPEAT period in HOLD.
REQ-004 Parameter CNT_W, default 24: counter width; every *_CYC value lies in 1..2^CNT_W-1.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 key_n  input  1  debounced key level; 0 = pressed; synchronous to clk.
REQ-008 event_ready  input  1  consumer accepts the pending event.
REQ-009 ovr_clr  input  1  clears overrun.
REQ-010 event_valid  output  1  an event is pending.
REQ-011 event_code  output  2  event type: 0 CLICK, 1 DCLICK, 2 LONG, 3 REPEAT.
REQ-012 overrun  output  1  sticky flag; set when an event was dropped.

Function
REQ-013 key_n shall be registered once into key_q; the FSM shall act only on key_q.
REQ-014 The FSM shall have five states: IDLE, PRESS1, WAIT2, PRESS2, HOLD.
REQ-015 The counter shall clear to 0 on every state change.
REQ-016 Otherwise the counter shall increment by 1 per cycle, saturating at 2^CNT_W-1.
REQ-017 IDLE: key_q=0 -> PRESS1.
REQ-018 PRESS1: key_q=1 -> WAIT2.
REQ-019 PRESS1: key_q=0 with counter=LONG_CYC-1 -> HOLD and issue LONG.
REQ-020 PRESS1: if release and the terminal count coincide, release shall win.
REQ-021 WAIT2: key_q=0 -> PRESS2.
REQ-022 WAIT2: counter=DCLK_CYC-1 with key_q=1 -> IDLE and issue CLICK.
REQ-023 WAIT2: if a press and the terminal count coincide, the press shall win.
REQ-024 PRESS2: key_q=1 -> IDLE and issue DCLICK, regardless of hold duration.
REQ-025 PRESS2 shall perform no long-press detection.
REQ-026 HOLD: key_q=1 -> IDLE, issuing no event.
REQ-027 "Issue" means loading the event into the output register at the same edge as the FSM transition; event_valid rises after that edge.
REQ-028 The event shall be loaded if event_valid=0, or if event_valid=1 and event_ready=1 in that cycle (simultaneous accept and load yields the new event).
REQ-029 If event_valid=1 and event_ready=0 when an event is issued, the new event shall be dropped and overrun set to 1.
REQ-030 The FSM shall never stall on the handshake.
REQ-031 event_valid and event_code shall hold stable until accepted.
REQ-032 event_valid shall clear on an accept edge with no new issue.
REQ-033 overrun shall clear when ovr_clr=1; a set in the same cycle shall win over the clear.
REQ-034 Latency: press edge on key_n -> PRESS1 two edges later; key_n release in PRESS1 -> CLICK issued 2+DCLK_CYC edges after the release edge.

Reset
REQ-035 rst_n=0 shall asynchronously force: state IDLE, counter 0, key_q 1, event_valid 0, event_code 0, overrun 0.
REQ-036 Deassertion shall take effect at the next clock edge.
REQ-037 Reset mid-sequence shall discard any partial sequence and pending event.
REQ-038 After reset, a key still held shall be treated as a new press.

Configuration
REQ-039 Macro KEY_AUTO_REPEAT_EN defined: HOLD issues REPEAT each time the counter reaches REPEAT_CYC-1 with key_q=0, then the counter restarts at 0.
REQ-040 Macro KEY_AUTO_REPEAT_EN undefined: HOLD issues nothing, event_code 3 never appears, and the REPEAT logic shall not be synthesised.

Verification
REQ-041 Press 10 cycles, release, stay idle 60 cycles, event_ready=1 -> exactly one CLICK (code 0); event_valid high for 1 cycle.
REQ-042 Press 10, release 15, press 10, release -> exactly one DCLICK (code 1); no CLICK.
REQ-043 Hold 200 cycles, macro undefined -> one LONG (code 2) about 102 cycles after press, nothing on release.
REQ-044 Same hold, macro defined -> LONG, then REPEAT (code 3) every 20 cycles while held (4 REPEATs in 200-cycle hold).
REQ-045 event_ready=0, LONG then REPEAT issued -> event_valid stays 1 with code 2, overrun=1; ovr_clr pulse -> overrun=0.
REQ-046 rst_n low for 3 cycles during WAIT2 -> all outputs 0 immediately, no CLICK afterwards.
